uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. Captures each completed frame the receiver presents on its data/ready outputs, acknowledges it with a one-cycle `data_readed` pulse, and stores data plus parity-error flag in a synchronous FIFO. Exposes a valid/ready read port to the host logic, with occupancy, full/empty and a sticky overflow flag for frames lost here or upstream.

## Interface
- `DATA_LEN`, 8: data bits per frame; must match the receiver.
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `ADDR_W`, 4: log2(DEPTH).
- `clk` in 1: system clock, same domain as the receiver.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in DATA_LEN: receiver output data.
- `rx_data_ready` in 1: receiver holds a completed frame.
- `rx_parity_error` in 1: parity error for the held frame.
- `rx_overwritten` in 1: receiver lost a frame before acknowledge.
- `rx_data_readed` out 1: acknowledge pulse to the receiver, one cycle per capture.
- `rd_data` out DATA_LEN: head-of-FIFO data, valid while `rd_valid`.
- `rd_parity_err` out 1: parity-error flag stored with the head entry.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts the head entry on this edge when `rd_valid`.
- `count` out ADDR_W+1: entries stored, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky lost-frame flag.
- `clr_overflow` in 1: clears `overflow`.

## Operation
- Capture FSM, three states: IDLE, ACK, WAIT_CLR.
  - IDLE: on `rx_data_ready=1`, write `{rx_parity_error, rx_data}` at this edge if not full; if full, drop the frame and set `overflow`. Go to ACK.
  - ACK: `rx_data_readed=1` (registered, decoded from state). Unconditionally go to WAIT_CLR.
  - WAIT_CLR: `rx_data_readed=0`; return to IDLE when `rx_data_ready=0`; otherwise stay. This guarantees exactly one capture per frame.
- Storage: DEPTH x (DATA_LEN+1) array, write pointer and read pointer of ADDR_W bits, wrapping modulo DEPTH. `count` is a separate ADDR_W+1 bit counter.
- Read: `rd_data`/`rd_parity_err` show `mem[rd_ptr]` (first-word-fall-through). A pop occurs when `rd_valid && rd_ready`. `rd_ready` while empty is ignored.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. When full, a simultaneous pop does not free a slot for the same-edge push; the push is dropped and overflow is set.
- `overflow` is set by a dropped push or by `rx_overwritten=1` sampled in any state. It is cleared by `clr_overflow`; set wins over a same-cycle clear.
- Reset values: state IDLE, pointers 0, `count=0`, `empty=1`, `full=0`, `rd_valid=0`, `rx_data_readed=0`, `overflow=0`. `rd_data`/`rd_parity_err` are don't-care while empty; memory is not cleared.
- Reset mid-handshake: the FSM returns to IDLE. A frame still held by the receiver is captured again after reset; this is accepted behaviour.

## Timing
- Capture edge E (IDLE, `rx_data_ready=1`): after E, `count` is incremented and `rd_valid=1`.
- `rx_data_readed` is high for the single cycle after E. The receiver drops `rx_data_ready` one edge later; the FSM re-enters IDLE one edge after that.
- Minimum spacing between captures is 3 cycles, far below the bit period.
- Pop at edge P: the next entry or `empty` is visible after P. No read latency beyond first-word-fall-through.
- All outputs are registered except `rd_data`, `rd_parity_err`, `rd_valid`, `full` and `empty`, which decode directly from registers.

## Structure
- Shared `uart_defs.vh` holds the FSM state encodings (IDLE=2'd0, ACK=2'd1, WAIT_CLR=2'd2) and the parity/stop-bit setting constants already used by rx/tx.
- One sub-module, `sync_fifo`: parameterised storage, pointers, count, full/empty, push/pop.
- `uart_rx_fifo` contains the capture FSM, the overflow logic, and the `sync_fifo` instance.

## Test plan
- Single frame 0xA5, no parity error -> `rx_data_readed` one pulse, `count=1`, `rd_data=0xA5`, `rd_parity_err=0`; `rd_ready` pulse -> `empty=1`.
- `rx_data_ready` held high for 10 cycles (receiver not clearing) -> exactly one capture, FSM stays in WAIT_CLR, `count=1`.
- 16 frames 0x00..0x0F, then 17th frame 0xFF -> `full=1`, 17th frame dropped, `overflow=1`; pops return 0x00..0x0F in order, with wrap verified on a second fill.
- Push coincident with pop at `count=5` -> `count` stays 5; the popped value is the oldest entry; the new value appears last.
- `rx_overwritten` pulse together with `clr_overflow` -> `overflow=1`; a later `clr_overflow` alone -> `overflow=0`. Frame 0x3C with `rx_parity_error=1` -> `rd_parity_err=1` at the head.
- `rst` low during ACK -> all outputs at reset values next cycle; after release, the held frame is captured once.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: capture FSM encodings and line-setting constants.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } cap_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int STOP_BITS_1 = 1;
  localparam int STOP_BITS_2 = 2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side handshake plus host read port of the UART receive buffer.
interface uart_rx_fifo_if #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_W   = 4
);
  logic [DATA_LEN-1:0] rx_data;
  logic                rx_data_ready;
  logic                rx_parity_error;
  logic                rx_overwritten;
  logic                rx_data_readed;
  logic [DATA_LEN-1:0] rd_data;
  logic                rd_parity_err;
  logic                rd_valid;
  logic                rd_ready;
  logic [ADDR_W:0]     count;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                clr_overflow;

  modport master (
    output rx_data, rx_data_ready, rx_parity_error, rx_overwritten, rd_ready, clr_overflow,
    input  rx_data_readed, rd_data, rd_parity_err, rd_valid, count, full, empty, overflow
  );

  modport slave (
    input  rx_data, rx_data_ready, rx_parity_error, rx_overwritten, rd_ready, clr_overflow,
    output rx_data_readed, rd_data, rd_parity_err, rd_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [ADDR_W:0]  count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_en, rd_en;

  // Full is judged on the pre-edge count, so a same-edge pop never makes room.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures one frame per receiver handshake into a FIFO; tracks frames lost here or upstream.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  cap_state_e          state_q, state_d;
  logic                push, drop, full, overflow_q;
  logic [DATA_LEN:0]   head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // WAIT_CLR holds until the receiver releases ready, so a held frame is taken once.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_data_ready) begin
        push    = 1'b1;
        state_d = ACK;
      end
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!bus.rx_data_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign drop = push && full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              overflow_q <= 1'b0;
    else if (drop || bus.rx_overwritten)   overflow_q <= 1'b1;
    else if (bus.clr_overflow)             overflow_q <= 1'b0;
  end

  sync_fifo #(
    .WIDTH  (DATA_LEN + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.rx_parity_error, bus.rx_data}),
    .pop   (bus.rd_ready),
    .rdata (head),
    .count (bus.count),
    .full  (full),
    .empty (bus.empty)
  );

  assign bus.rx_data_readed = (state_q == ACK);
  assign bus.rd_data        = head[DATA_LEN-1:0];
  assign bus.rd_parity_err  = head[DATA_LEN];
  assign bus.rd_valid       = !bus.empty;
  assign bus.full           = full;
  assign bus.overflow       = overflow_q;
endmodule
